// File: rtl/rpn_expr_driver_if.sv
// rtl/rpn_expr_driver_if.sv - token stream and ALU command bus for rpn_expr_driver
//
// Token stream (source -> driver):
//   tok_valid   token present
//   tok_ready   driver accepts token; transfer on valid & ready at posedge
//   tok_type    00 operand, 01 add, 10 mul, 11 end
//   tok_value   signed operand, meaningful only when tok_type = 00
// ALU bus (driver <-> stack ALU):
//   alu_opcode  000 NOP, 100 add, 101 mul, 110 push, 111 pop
//   alu_data    ALU input_data
//   alu_result  ALU output_data
//   alu_overflow, alu_success  ALU status flags
// Modports: master = the driver, slave = token source plus ALU side.

interface rpn_expr_driver_if #(
    parameter int N = 8
);
    logic         tok_valid;
    logic         tok_ready;
    logic [1:0]   tok_type;
    logic [N-1:0] tok_value;
    logic [2:0]   alu_opcode;
    logic [N-1:0] alu_data;
    logic [N-1:0] alu_result;
    logic         alu_overflow;
    logic         alu_success;

    modport master (
        input  tok_valid, tok_type, tok_value, alu_result, alu_overflow, alu_success,
        output tok_ready, alu_opcode, alu_data
    );

    modport slave (
        output tok_valid, tok_type, tok_value, alu_result, alu_overflow, alu_success,
        input  tok_ready, alu_opcode, alu_data
    );
endinterface

// File: rtl/rpn_expr_driver.sv
// rtl/rpn_expr_driver.sv - RPN token stream to stack-ALU command sequencer
//
// Ports:
//   clk       system clock, shared with the ALU
//   rst       asynchronous active-low reset
//   bus       rpn_expr_driver_if.master: token stream in, ALU commands out
//   busy      high in every state except IDLE
//   done      one-cycle pulse when an expression completes
//   result    signed final value, held until the next done
//   overflow  sticky OR of ALU overflow over the expression's add/mul ops
//   error     expression malformed or an ALU command failed
//
// Every ALU command is an ISS cycle (opcode/data driven) followed by a CHK
// cycle (NOP driven, ALU status sampled at its closing edge).

module rpn_expr_driver #(
    parameter int N        = 8,
    parameter int MAX_SIZE = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    rpn_expr_driver_if.master      bus,
    output logic                   busy,
    output logic                   done,
    output logic [N-1:0]           result,
    output logic                   overflow,
    output logic                   error
);
    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_PUSH_ISS  = 4'd1;
    localparam logic [3:0] S_PUSH_CHK  = 4'd2;
    localparam logic [3:0] S_OP_ISS    = 4'd3;
    localparam logic [3:0] S_OP_CHK    = 4'd4;
    localparam logic [3:0] S_POP1_ISS  = 4'd5;
    localparam logic [3:0] S_POP1_CHK  = 4'd6;
    localparam logic [3:0] S_POP2_ISS  = 4'd7;
    localparam logic [3:0] S_POP2_CHK  = 4'd8;
    localparam logic [3:0] S_PUSHR_ISS = 4'd9;
    localparam logic [3:0] S_PUSHR_CHK = 4'd10;
    localparam logic [3:0] S_FIN_ISS   = 4'd11;
    localparam logic [3:0] S_FIN_CHK   = 4'd12;
    localparam logic [3:0] S_DRAIN_ISS = 4'd13;
    localparam logic [3:0] S_DRAIN_CHK = 4'd14;
    localparam logic [3:0] S_DONE      = 4'd15;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_PUSH = 3'b110;
    localparam logic [2:0] OP_POP  = 3'b111;

    // Stack depth is owned by the ALU; the driver only learns about a full
    // or empty stack through alu_success, so no logic depends on it.
    if (MAX_SIZE < 1) begin : g_depth_unused
    end

    logic [3:0]   state_q, state_d;
    logic [N-1:0] operand_q, operand_d;
    logic         is_mul_q, is_mul_d;
    logic [N-1:0] tmp_q, tmp_d;
    logic [N-1:0] result_q, result_d;
    logic         ovf_q, ovf_d;
    logic         err_q, err_d;
    logic         done_seen_q, done_seen_d;   // flags belong to a finished expression
    logic [2:0]   opcode_q, opcode_d;
    logic [N-1:0] data_q, data_d;
    logic         ready_q, ready_d;

    always_comb begin
        state_d     = state_q;
        operand_d   = operand_q;
        is_mul_d    = is_mul_q;
        tmp_d       = tmp_q;
        result_d    = result_q;
        ovf_d       = ovf_q;
        err_d       = err_q;
        done_seen_d = done_seen_q;

        case (state_q)
            S_IDLE: begin
                if (bus.tok_valid && ready_q) begin
                    // First token of a new expression drops the previous status.
                    if (done_seen_q) begin
                        ovf_d       = 1'b0;
                        err_d       = 1'b0;
                        done_seen_d = 1'b0;
                    end
                    case (bus.tok_type)
                        2'b00: begin
                            operand_d = bus.tok_value;
                            state_d   = S_PUSH_ISS;
                        end
                        2'b01: begin
                            is_mul_d = 1'b0;
                            state_d  = S_OP_ISS;
                        end
                        2'b10: begin
                            is_mul_d = 1'b1;
                            state_d  = S_OP_ISS;
                        end
                        default: state_d = S_FIN_ISS;
                    endcase
                end
            end
            S_PUSH_ISS:  state_d = S_PUSH_CHK;
            S_OP_ISS:    state_d = S_OP_CHK;
            S_POP1_ISS:  state_d = S_POP1_CHK;
            S_POP2_ISS:  state_d = S_POP2_CHK;
            S_PUSHR_ISS: state_d = S_PUSHR_CHK;
            S_FIN_ISS:   state_d = S_FIN_CHK;
            S_DRAIN_ISS: state_d = S_DRAIN_CHK;
            S_OP_CHK: begin
                if (bus.alu_success) begin
                    tmp_d   = bus.alu_result;
                    ovf_d   = ovf_q | bus.alu_overflow;
                    state_d = S_POP1_ISS;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_DRAIN_ISS;
                end
            end
            // The ALU leaves both operands stacked after add/mul, so the
            // result only goes back once both have been popped.
            S_POP1_CHK, S_POP2_CHK, S_PUSH_CHK, S_PUSHR_CHK: begin
                if (bus.alu_success) begin
                    if (state_q == S_POP1_CHK)      state_d = S_POP2_ISS;
                    else if (state_q == S_POP2_CHK) state_d = S_PUSHR_ISS;
                    else                            state_d = S_IDLE;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_DRAIN_ISS;
                end
            end
            S_FIN_CHK: begin
                if (bus.alu_success) begin
                    result_d = bus.alu_result;
                    state_d  = S_DRAIN_ISS;
                end else begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = S_DONE;
                end
            end
            // Any value still popped here is a leftover operand, or debris
            // after an earlier error; either way error ends up set.
            S_DRAIN_CHK: begin
                if (bus.alu_success) begin
                    err_d   = 1'b1;
                    state_d = S_DRAIN_ISS;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_seen_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Command outputs are registered from the next state so that they
        // are valid exactly during the ISS cycle.
        opcode_d = OP_NOP;
        data_d   = '0;
        case (state_d)
            S_PUSH_ISS: begin
                opcode_d = OP_PUSH;
                data_d   = operand_d;
            end
            S_PUSHR_ISS: begin
                opcode_d = OP_PUSH;
                data_d   = tmp_d;
            end
            S_OP_ISS: opcode_d = is_mul_d ? OP_MUL : OP_ADD;
            S_POP1_ISS, S_POP2_ISS, S_FIN_ISS, S_DRAIN_ISS: opcode_d = OP_POP;
            default: opcode_d = OP_NOP;
        endcase
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            operand_q   <= '0;
            is_mul_q    <= 1'b0;
            tmp_q       <= '0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            done_seen_q <= 1'b0;
            opcode_q    <= OP_NOP;
            data_q      <= '0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            operand_q   <= operand_d;
            is_mul_q    <= is_mul_d;
            tmp_q       <= tmp_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
            done_seen_q <= done_seen_d;
            opcode_q    <= opcode_d;
            data_q      <= data_d;
            ready_q     <= ready_d;
        end
    end

    assign bus.tok_ready  = ready_q;
    assign bus.alu_opcode = opcode_q;
    assign bus.alu_data   = data_q;
    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_DONE);
    assign result         = result_q;
    assign overflow       = ovf_q;
    assign error          = err_q;
endmodule

// File: doc/rpn_expr_driver.md
Name: rpn_expr_driver

Overview:
- Command-issuing master for the stack-based ALU. It accepts a postfix (RPN) token stream over a valid/ready handshake and translates each token into ALU opcode sequences: push, add/mul, pop, pop, push-result.
- It checks every ALU success flag. At end-of-expression it returns the final value with sticky overflow and error status, and it always leaves the ALU stack empty.
- It sits between the token source and the ALU's opcode/input_data/output_data/overflow/success interface.

Parameters:
- N, 8, operand/result width, must match the ALU.
- MAX_SIZE, 4, ALU stack depth; informational only, no driver logic depends on it.

Ports:
- clk  in  1  system clock, shared with the ALU.
- rst  in  1  asynchronous, active-low reset.
- tok_valid  in  1  token present.
- tok_ready  out  1  driver accepts token; token transfers when valid&ready at posedge.
- tok_type  in  2  00 operand, 01 add, 10 mul, 11 end.
- tok_value  in  N  signed operand; ignored unless tok_type=00.
- alu_opcode  out  3  to ALU opcode: 000 NOP, 100 add, 101 mul, 110 push, 111 pop.
- alu_data  out  N  to ALU input_data.
- alu_result  in  N  from ALU output_data.
- alu_overflow  in  1  from ALU overflow.
- alu_success  in  1  from ALU success.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when an expression completes.
- result  out  N  signed final value; held until the next done.
- overflow  out  1  sticky OR of alu_overflow over the expression's add/mul ops.
- error  out  1  expression malformed or ALU command failed.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; alu_opcode=000, alu_data=0, tok_ready=0, busy=0, done=0, result=0, overflow=0, error=0. Reset mid-sequence abandons the sequence immediately. The driver does not clear the ALU stack; integration ties the ALU reset to the same net.
- Command timing: each ALU command takes two cycles.
  - ISS state: opcode/data are registered outputs valid for exactly one cycle.
  - CHK state: opcode=000, and alu_success/alu_result/alu_overflow are sampled at the end of CHK.
  - alu_opcode is 000 in every non-ISS state.
- IDLE: tok_ready=1. On transfer:
  - If done was issued previously, first clear overflow and error.
  - tok 00: latch tok_value → PUSH_ISS.
  - tok 01/10: → OP_ISS.
  - tok 11: → FIN_ISS.
- PUSH_ISS/CHK: opcode 110, data=operand. success=1 → IDLE; success=0 (stack full) → error=1, → DRAIN_ISS.
- OP_ISS/CHK: opcode 100 or 101.
  - success=1: tmp=alu_result; overflow|=alu_overflow; → POP1_ISS.
  - success=0 (fewer than 2 operands): error=1 → DRAIN_ISS.
- POP1_ISS/CHK, then POP2_ISS/CHK: opcode 111. The ALU leaves both operands stacked, so both pops must succeed. Any failure sets error=1 → DRAIN_ISS.
- PUSHR_ISS/CHK: opcode 110, data=tmp. success → IDLE.
- FIN_ISS/CHK: opcode 111.
  - success=1: result=alu_result → DRAIN_ISS. Any further successful drain pop means leftover operands: error=1.
  - success=0 (empty expression): result=0, error=1 → DONE.
- DRAIN_ISS/CHK: opcode 111, repeated until success=0, then → DONE. result is not updated by drain pops.
- DONE: done=1 for one cycle, busy=1 → IDLE.
- Latencies, counted from the transfer edge to the return to IDLE:
  - Operand: 2 cycles.
  - Operator: 8 cycles.
  - End with one value: 2 (FIN) + 2 (drain check) + 1 (DONE) = 5 cycles to the done pulse.
- Arithmetic: result and tmp are the ALU's N-bit wrapped values; no width extension in the driver.
- tok_valid outside IDLE is ignored (tok_ready=0); the token must be held until accepted.

Test Plan (N=8, MAX_SIZE=4):
- 3, 4, add, end → done with result=7, overflow=0, error=0; exactly 5 cycles from end-token transfer to done; ALU stack empty after (a pop returns success=0).
- 100, 2, mul, end → result=8'hC8 (-56), overflow=1, error=0. A following 1, end → overflow=0 (sticky flags cleared).
- 5, add, end → add fails → error=1, drain pops 5. The end token is accepted after the preceding done, then FIN fails → result=0, error=1. Stack empty.
- 1, 2, 3, 4, 5 → the 5th push sees success=0 → error=1, four drain pops, done, stack empty.
- 1, 2, end → result=2, error=1 (leftover operand drained), done, stack empty.
- 3, 4, add with rst driven low during POP1_CHK → all outputs at reset values within the same cycle (no clock edge needed), alu_opcode=000. After release, tok_ready=1.
